// File: rtl/uivtc_mwin.sv
// uivtc_mwin: multi-window video timing controller.
// Generates HS/VS/DE for one raster, N_WIN overlay window strobes, output
// coordinates and a frame-start pulse. Window geometry sits in shadow registers
// that are reloaded only at the frame boundary, so overlays never tear.
// Optional feature macro: UIVTC_MWIN_PRIO_EN adds O_win_top / O_win_any.
module uivtc_mwin #(
    parameter int CNT_W        = 12,
    parameter int N_WIN        = 4,
    parameter int H_ActiveSize = 1024,
    parameter int H_FrameSize  = 1344,
    parameter int H_SyncStart  = 1164,
    parameter int H_SyncEnd    = 1184,
    parameter int V_ActiveSize = 600,
    parameter int V_FrameSize  = 635,
    parameter int V_SyncStart  = 620,
    parameter int V_SyncEnd    = 623,
    parameter int HS_POL       = 1,
    parameter int VS_POL       = 1
) (
    input  logic                   I_vtc_clk,
    input  logic                   I_vtc_rstn,
    input  logic                   I_vtc_en,
    input  logic [N_WIN*CNT_W-1:0] I_win_x,
    input  logic [N_WIN*CNT_W-1:0] I_win_y,
    input  logic [N_WIN*CNT_W-1:0] I_win_w,
    input  logic [N_WIN*CNT_W-1:0] I_win_h,
    input  logic [N_WIN-1:0]       I_win_en,
    input  logic                   I_cfg_upd,
    output logic                   O_cfg_ack,
    output logic                   O_vtc_hs,
    output logic                   O_vtc_vs,
    output logic                   O_vtc_de,
    output logic [N_WIN-1:0]       O_win_de,
    output logic [CNT_W-1:0]       O_vtc_x,
    output logic [CNT_W-1:0]       O_vtc_y,
    output logic                   O_vtc_fs
`ifdef UIVTC_MWIN_PRIO_EN
    ,
    output logic [((N_WIN > 1) ? $clog2(N_WIN) : 1)-1:0] O_win_top,
    output logic                   O_win_any
`endif
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_FrameSize - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_FrameSize - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ActiveSize);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ActiveSize);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_SyncStart);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SyncEnd);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_SyncStart);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SyncEnd);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    typedef enum logic {IDLE, PEND} state_t;

    logic [1:0]       rst_sync;
    logic             gate;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             line_end, frame_end, load_cond, load;
    logic             de_now, hs_now, vs_now;
    logic [N_WIN-1:0] win_hit;
    logic [CNT_W-1:0] x_s [N_WIN];
    logic [CNT_W-1:0] y_s [N_WIN];
    logic [CNT_W-1:0] w_s [N_WIN];
    logic [CNT_W-1:0] h_s [N_WIN];
    logic [N_WIN-1:0] en_s;
    state_t           state, state_next;

    // The raster only runs once reset release has passed the synchroniser and en is high.
    assign gate      = rst_sync[1] & I_vtc_en;
    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign load_cond = frame_end || !gate;

    // Two-flop synchroniser for reset release; assertion stays asynchronous.
    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end

    // Raster counters; vcnt steps at the end of every full line.
    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn || !gate) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= frame_end ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Shadow update FSM: a request waits for the frame boundary (or a stopped raster).
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: if (I_cfg_upd) begin
                if (load_cond) load = 1'b1;
                else           state_next = PEND;
            end
            PEND: if (load_cond) begin
                load       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register and the acknowledge pulse for the load.
    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn) begin
            state     <= IDLE;
            O_cfg_ack <= 1'b0;
        end else begin
            state     <= state_next;
            O_cfg_ack <= load;
        end
    end

    // Shadow geometry registers, sampled from the inputs at load time.
    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn) begin
            en_s <= '0;
            for (int i = 0; i < N_WIN; i++) begin
                x_s[i] <= '0;
                y_s[i] <= '0;
                w_s[i] <= '0;
                h_s[i] <= '0;
            end
        end else if (load) begin
            en_s <= I_win_en;
            for (int i = 0; i < N_WIN; i++) begin
                x_s[i] <= I_win_x[i*CNT_W +: CNT_W];
                y_s[i] <= I_win_y[i*CNT_W +: CNT_W];
                w_s[i] <= I_win_w[i*CNT_W +: CNT_W];
                h_s[i] <= I_win_h[i*CNT_W +: CNT_W];
            end
        end
    end

    // Raster and window decode; window ends are summed one bit wider so they never wrap.
    always_comb begin
        de_now  = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_now  = (hcnt >= H_SS) && (hcnt < H_SE);
        vs_now  = (vcnt >= V_SS) && (vcnt < V_SE);
        win_hit = '0;
        for (int i = 0; i < N_WIN; i++) begin
            win_hit[i] = en_s[i] && de_now
                && (hcnt >= x_s[i]) && ({1'b0, hcnt} < ({1'b0, x_s[i]} + {1'b0, w_s[i]}))
                && (vcnt >= y_s[i]) && ({1'b0, vcnt} < ({1'b0, y_s[i]} + {1'b0, h_s[i]}));
        end
    end

    // Registered outputs; everything drops to its inactive level while the raster is stopped.
    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn || !gate) begin
            O_vtc_hs <= ~HS_ON;
            O_vtc_vs <= ~VS_ON;
            O_vtc_de <= 1'b0;
            O_win_de <= '0;
            O_vtc_x  <= '0;
            O_vtc_y  <= '0;
            O_vtc_fs <= 1'b0;
        end else begin
            O_vtc_hs <= hs_now ? HS_ON : ~HS_ON;
            O_vtc_vs <= vs_now ? VS_ON : ~VS_ON;
            O_vtc_de <= de_now;
            O_win_de <= win_hit;
            O_vtc_x  <= hcnt;
            O_vtc_y  <= vcnt;
            O_vtc_fs <= (hcnt == '0) && (vcnt == '0);
        end
    end

`ifdef UIVTC_MWIN_PRIO_EN
    localparam int TOP_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
    logic [TOP_W-1:0] top_next;

    // Highest-numbered active window wins; later iterations overwrite earlier ones.
    always_comb begin
        top_next = '0;
        for (int i = 0; i < N_WIN; i++) begin
            if (gate && win_hit[i]) top_next = TOP_W'(i);
        end
    end

    // Priority index registered alongside O_win_de.
    always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
        if (!I_vtc_rstn) O_win_top <= '0;
        else             O_win_top <= top_next;
    end

    assign O_win_any = |O_win_de;
`endif

endmodule

// File: tb/tb_uivtc_mwin.sv
// Directed testbench for uivtc_mwin on a small 12x7 raster with two windows.
module tb_uivtc_mwin;

    localparam int CW = 12;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst_n, en, cfg_upd;
    logic [NW*CW-1:0] win_x, win_y, win_w, win_h;
    logic [NW-1:0]   win_en;
    logic            ack, hs, vs, de, fs;
    logic [NW-1:0]   win_de;
    logic [CW-1:0]   ox, oy;
`ifdef UIVTC_MWIN_PRIO_EN
    logic            win_top;
    logic            win_any;
`endif

    int checks = 0;
    int failures = 0;
    int deCnt, deBad, hsCnt, hsBad, vsLow, vsBad, fsCnt, xyBad;
    int w0Cnt, w0Bad, w1Cnt, w1Bad, ackCnt, ackPos, prioBad;

    uivtc_mwin #(
        .CNT_W(CW), .N_WIN(NW),
        .H_ActiveSize(8), .H_FrameSize(12), .H_SyncStart(9), .H_SyncEnd(10),
        .V_ActiveSize(4), .V_FrameSize(7), .V_SyncStart(5), .V_SyncEnd(6),
        .HS_POL(1), .VS_POL(0)
    ) dut (
        .I_vtc_clk(clk), .I_vtc_rstn(rst_n), .I_vtc_en(en),
        .I_win_x(win_x), .I_win_y(win_y), .I_win_w(win_w), .I_win_h(win_h),
        .I_win_en(win_en), .I_cfg_upd(cfg_upd), .O_cfg_ack(ack),
        .O_vtc_hs(hs), .O_vtc_vs(vs), .O_vtc_de(de), .O_win_de(win_de),
        .O_vtc_x(ox), .O_vtc_y(oy), .O_vtc_fs(fs)
`ifdef UIVTC_MWIN_PRIO_EN
        , .O_win_top(win_top), .O_win_any(win_any)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input int x, input int y, input int w,
                                 input int h, input bit wen);
        win_x[idx*CW +: CW] = CW'(x);
        win_y[idx*CW +: CW] = CW'(y);
        win_w[idx*CW +: CW] = CW'(w);
        win_h[idx*CW +: CW] = CW'(h);
        win_en[idx]         = wen;
    endtask

    // Walks one 84-cycle frame from its fs sample, comparing against a raster model.
    task automatic measureFrame(input int updAt,
                                input int x0, input int w0, input int y0, input int h0,
                                input int x1, input int w1, input int y1, input int h1);
        int ex, ey;
        bit deExp, e0, e1;
        deCnt = 0; deBad = 0; hsCnt = 0; hsBad = 0; vsLow = 0; vsBad = 0; fsCnt = 0;
        xyBad = 0; w0Cnt = 0; w0Bad = 0; w1Cnt = 0; w1Bad = 0; ackCnt = 0; ackPos = -1;
        prioBad = 0;
        for (int c = 0; c < 84; c++) begin
            ex = c % 12;
            ey = c / 12;
            deExp = (ex < 8) && (ey < 4);
            e0 = deExp && ex >= x0 && ex < x0 + w0 && ey >= y0 && ey < y0 + h0;
            e1 = deExp && ex >= x1 && ex < x1 + w1 && ey >= y1 && ey < y1 + h1;
            if (ox !== CW'(ex) || oy !== CW'(ey)) xyBad++;
            if (de !== deExp) deBad++;
            if (de === 1'b1) deCnt++;
            if (hs === 1'b1) begin
                hsCnt++;
                if (ex != 9) hsBad++;
            end
            if (vs === 1'b0) begin
                vsLow++;
                if (ey != 5) vsBad++;
            end
            if (fs === 1'b1) fsCnt++;
            if (win_de[0] === 1'b1) w0Cnt++;
            if (win_de[0] !== e0) w0Bad++;
            if (win_de[1] === 1'b1) w1Cnt++;
            if (win_de[1] !== e1) w1Bad++;
            if (ack === 1'b1) begin
                ackCnt++;
                ackPos = c;
            end
`ifdef UIVTC_MWIN_PRIO_EN
            if (win_top !== (e1 ? 1'b1 : 1'b0) || win_any !== (e0 | e1)) prioBad++;
`endif
            cfg_upd = (c == updAt);
            step(1);
        end
        cfg_upd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cfg_upd = 1'b0;
        win_x = '0; win_y = '0; win_w = '0; win_h = '0; win_en = '0;

        // Reset values, with active-low VS parked at its inactive high level.
        step(1);
        checkOutput("rst_vs", vs, 1);
        checkOutput("rst_hs", hs, 0);
        checkOutput("rst_de", de, 0);
        checkOutput("rst_fs_ack", {fs, ack}, 0);
        checkOutput("rst_xy", {ox, oy}, 0);

        // Release: two synchroniser edges, then the raster starts at (0,0).
        rst_n = 1'b1;
        step(2);
        checkOutput("sync_fs", fs, 0);
        checkOutput("sync_de", de, 0);
        step(1);
        checkOutput("first_fs", fs, 1);
        checkOutput("first_de", de, 1);
        checkOutput("first_xy", {ox, oy}, 0);

        // Frame 1: raster timing with no windows.
        measureFrame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f1_de_cnt", deCnt, 32);
        checkOutput("f1_de_bad", deBad, 0);
        checkOutput("f1_hs_cnt", hsCnt, 7);
        checkOutput("f1_hs_bad", hsBad, 0);
        checkOutput("f1_vs_low", vsLow, 12);
        checkOutput("f1_vs_bad", vsBad, 0);
        checkOutput("f1_fs_cnt", fsCnt, 1);
        checkOutput("f1_xy_bad", xyBad, 0);
        checkOutput("f1_period_fs", fs, 1);

        // Frame 2: request mid-frame; nothing changes until the boundary.
        applyStimulus(0, 2, 1, 3, 2, 1'b1);
        applyStimulus(1, 6, 3, 5, 9, 1'b1);
        measureFrame(20, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f2_w0_cnt", w0Cnt, 0);
        checkOutput("f2_w1_cnt", w1Cnt, 0);
        checkOutput("f2_ack_cnt", ackCnt, 1);
        checkOutput("f2_ack_pos", ackPos, 83);
        checkOutput("f2_next_fs", fs, 1);

        // Frame 3: new geometry, win1 clipped by the active area.
        measureFrame(-1, 2, 3, 1, 2, 6, 5, 3, 9);
        checkOutput("f3_w0_cnt", w0Cnt, 6);
        checkOutput("f3_w0_bad", w0Bad, 0);
        checkOutput("f3_w1_cnt", w1Cnt, 2);
        checkOutput("f3_w1_bad", w1Bad, 0);
        checkOutput("f3_ack_cnt", ackCnt, 0);

        // Frames 4-5: zero-width window never asserts.
        applyStimulus(0, 2, 1, 0, 2, 1'b1);
        measureFrame(10, 2, 3, 1, 2, 6, 5, 3, 9);
        checkOutput("f4_ack_pos", ackPos, 83);
        measureFrame(-1, 2, 0, 1, 2, 6, 5, 3, 9);
        checkOutput("f5_w0_cnt", w0Cnt, 0);
        checkOutput("f5_w0_bad", w0Bad, 0);
        checkOutput("f5_w1_cnt", w1Cnt, 2);

        // Frame 6: pending update, then en dropped at (4,2) for 10 cycles.
        applyStimulus(0, 2, 1, 5, 3, 1'b1);
        step(20);
        cfg_upd = 1'b1;
        step(1);
        cfg_upd = 1'b0;
        step(7);
        checkOutput("en_pre_xy", {ox, oy}, {12'd4, 12'd2});
        en = 1'b0;
        step(1);
        checkOutput("en_off_de", de, 0);
        checkOutput("en_off_xy", {ox, oy}, 0);
        checkOutput("en_off_sync", {hs, vs, fs}, 3'b010);
        checkOutput("en_off_ack", ack, 1);
        step(1);
        checkOutput("en_off_ack2", ack, 0);
        step(8);
        checkOutput("en_hold_de", de, 0);
        en = 1'b1;
        step(1);
        checkOutput("reen_fs", fs, 1);
        checkOutput("reen_xy", {ox, oy}, 0);
        checkOutput("reen_de", de, 1);

        // Frame 7: geometry loaded during the stop, with win0/win1 overlapping at (6,3).
        measureFrame(-1, 2, 5, 1, 3, 6, 5, 3, 9);
        checkOutput("f7_w0_cnt", w0Cnt, 15);
        checkOutput("f7_w0_bad", w0Bad, 0);
        checkOutput("f7_w1_cnt", w1Cnt, 2);
        checkOutput("f7_fs_cnt", fsCnt, 1);
`ifdef UIVTC_MWIN_PRIO_EN
        checkOutput("f7_prio_bad", prioBad, 0);
`endif

        // Asynchronous reset mid-line, observed before any clock edge.
        step(2);
        checkOutput("pre_rst_x", ox, 2);
        checkOutput("pre_rst_de", de, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_de", de, 0);
        checkOutput("arst_xy", {ox, oy}, 0);
        checkOutput("arst_sync", {hs, vs}, 2'b01);
        checkOutput("arst_fs_ack_win", {fs, ack, win_de}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uivtc_mwin.md
Name: uivtc_mwin

Overview:
Parametrised multi-window video timing controller; next generation of the single-overlay VTC.
- Generates HS/VS/DE for one main raster, with configurable sync polarity.
- Generates N_WIN independent overlay-window DE strobes, plus pixel coordinates and a frame-start pulse.
- Window geometry is runtime-programmable through shadow registers that apply only at a frame boundary, so overlays never tear.
- Sits between the clock/reset block and the video mixer/HDMI TX.

Parameters:
CNT_W, 12, counter and coordinate width (bits)
N_WIN, 4, number of overlay windows (1..8)
H_ActiveSize, 1024, active pixels per line
H_FrameSize, 1344, total clocks per line
H_SyncStart, 1164, hcnt value where HS asserts
H_SyncEnd, 1184, hcnt value where HS deasserts
V_ActiveSize, 600, active lines per frame
V_FrameSize, 635, total lines per frame
V_SyncStart, 620, vcnt value where VS asserts
V_SyncEnd, 623, vcnt value where VS deasserts
HS_POL, 1, 1 = active-high HS, 0 = active-low HS
VS_POL, 1, 1 = active-high VS, 0 = active-low VS

Ports:
I_vtc_clk  in  1  pixel clock
I_vtc_rstn  in  1  asynchronous active-low reset
I_vtc_en  in  1  run enable; low holds the raster at origin
I_win_x  in  N_WIN*CNT_W  window left edge, window i at [i*CNT_W +: CNT_W]
I_win_y  in  N_WIN*CNT_W  window top edge
I_win_w  in  N_WIN*CNT_W  window width in pixels
I_win_h  in  N_WIN*CNT_W  window height in lines
I_win_en  in  N_WIN  per-window enable
I_cfg_upd  in  1  one-cycle request to load the I_win_* inputs into the shadow registers
O_cfg_ack  out  1  one-cycle pulse when the shadow load takes effect
O_vtc_hs  out  1  line sync, polarity per HS_POL
O_vtc_vs  out  1  frame sync, polarity per VS_POL
O_vtc_de  out  1  main active video
O_win_de  out  N_WIN  per-window active video
O_vtc_x  out  CNT_W  hcnt aligned to outputs
O_vtc_y  out  CNT_W  vcnt aligned to outputs
O_vtc_fs  out  1  frame-start pulse, aligned with pixel (0,0)

Behaviour:
- Reset: I_vtc_rstn low asynchronously clears all state.
  - hcnt = vcnt = 0; O_vtc_de, O_win_de, O_vtc_fs, O_cfg_ack, O_vtc_x, O_vtc_y = 0.
  - O_vtc_hs = ~HS_POL and O_vtc_vs = ~VS_POL (inactive level).
  - Shadow registers cleared; all windows disabled; pending flag = 0.
- Reset deassertion is synchronised internally by a 2-flop stage; counting starts on the 3rd rising edge after release.
- hcnt counts 0..H_FrameSize-1 and wraps to 0.
- vcnt increments when hcnt == H_FrameSize-1 (end of full line, not end of active line); it wraps from V_FrameSize-1 to 0.
- I_vtc_en low: hcnt and vcnt are held at 0 and all outputs go inactive on the next edge. When en returns high, the raster restarts at (0,0) and O_vtc_fs fires.
- Decode (half-open intervals):
  - de = hcnt < H_ActiveSize && vcnt < V_ActiveSize
  - hs active for hcnt in [H_SyncStart, H_SyncEnd)
  - vs active for vcnt in [V_SyncStart, V_SyncEnd), whole lines
  - win_de[i] = en_s[i] && hcnt in [x_s, x_s+w_s) && vcnt in [y_s, y_s+h_s) && de
  - Window sums are computed at CNT_W+1 bits, so there is no wrap.
  - w = 0 or h = 0 means the window is never active.
  - A window extending beyond the active area is clipped by the && de term.
- Latency: every output is registered; output at edge n reflects the counters at edge n-1. O_vtc_x/O_vtc_y are aligned with the DE outputs.
- Shadow update state machine, states IDLE and PEND:
  - IDLE: I_cfg_upd = 1 moves to PEND.
  - PEND: on the edge where hcnt == H_FrameSize-1 && vcnt == V_FrameSize-1, load the shadows from I_win_*, pulse O_cfg_ack, and return to IDLE. New geometry takes effect from pixel (0,0).
  - I_cfg_upd while in PEND is absorbed; the inputs are sampled at load time, not at request time.
  - I_cfg_upd arriving on the load edge itself: it is served by that load.
  - I_vtc_en low while in PEND: the load happens immediately on the next edge.
- O_vtc_fs is high for exactly one cycle, with output coordinates (0,0).

Optional Feature:
UIVTC_MWIN_PRIO_EN
- Defined: adds ports O_win_top (width $clog2(N_WIN), or 1 when N_WIN = 1) and O_win_any (1).
  - O_win_top is the index of the highest-numbered active window, registered and aligned with O_win_de.
  - O_win_any = |O_win_de.
  - When no window is active, O_win_top = 0.
- Undefined: neither port exists and no priority logic is built.

Test Plan:
Common parameters: H_ActiveSize=8, H_FrameSize=12, H_SyncStart=9, H_SyncEnd=10, V_ActiveSize=4, V_FrameSize=7, V_SyncStart=5, V_SyncEnd=6, HS_POL=1, VS_POL=0, N_WIN=2.

1. Reset release with en=1 -> O_vtc_vs=1 during reset.
   - The first O_vtc_fs coincides with O_vtc_de=1 and x=0, y=0.
   - O_vtc_de high 8 of every 12 cycles for 4 lines.
   - O_vtc_hs high only at x=9.
   - O_vtc_vs low for exactly 12 cycles at y=5.
   - Frame period 84 cycles.
2. Program win0 x=2 w=3 y=1 h=2 en=1, pulse I_cfg_upd mid-frame -> O_cfg_ack pulses one cycle before the next fs.
   - O_win_de[0] is not active in the current frame.
   - In the next frame it is high for x=2..4 on y=1..2 only (6 cycles/frame).
3. win1 x=6 w=5 y=3 h=9 -> clipped: O_win_de[1] high only at x=6..7, y=3 (2 cycles/frame).
4. win0 w=0 en=1 -> O_win_de[0] never asserts.
5. Drop I_vtc_en at y=2 x=4 for 10 cycles -> outputs inactive next edge.
   - A pending update is acked within 1 cycle.
   - On re-enable, fs with x=0, y=0.
6. Assert I_vtc_rstn low asynchronously mid-line -> outputs go to reset values without a clock edge.
   - With UIVTC_MWIN_PRIO_EN and overlapping win0/win1 enabled: O_win_top=1 in the overlap region.
